// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Issue-gating unit between fetch and decode. A per-register pending-write
//   scoreboard detects RAW hazards and WAW overflow, a small FSM blocks issue
//   while a branch is unresolved, and a sticky HALT state blocks all issue
//   until reset. A held instruction leaves NOP_INST in decode for that cycle.
//   Field extraction (source/dest indices, branch/halt flags) is done
//   upstream, so nothing here depends on the ISA.
//
//   Build option: define WB_BYPASS_EN to let a source that is waiting on its
//   last outstanding write issue in the same cycle as that writeback. This
//   relies on the register file writing before it reads.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid, in_inst      fetched instruction
//   rs_used/rs_idx         first source operand
//   rt_used/rt_idx         second source operand
//   wr_en/wr_idx           destination register
//   is_branch, is_halt     control-flow flags of the fetched instruction
//   wb_valid/wb_idx        writeback retiring one register write
//   br_resolve             one-cycle pulse: the outstanding branch is resolved
//   out_inst/out_valid     registered instruction to decode
//   stall                  combinational: hold PC/fetch this cycle
//   halted                 a halt has issued (sticky until rst)
//   err_underflow          sticky: writeback to a register with nothing pending
//
// FSM states
//   state  | meaning
//   IDLE   | normal issue, gated only by the scoreboard
//   SHADOW | branch issued, every fetch is held until br_resolve
//   HALT   | halt issued, every fetch is held; only rst leaves

module hazard_scoreboard #(
  parameter int          INST_W       = 16,
  parameter int          NUM_REGS     = 8,
  parameter int          REG_W        = 3,
  parameter int          MAX_INFLIGHT = 3,
  parameter int          CNT_W        = 2,
  parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  input  logic              rs_used,
  input  logic [REG_W-1:0]  rs_idx,
  input  logic              rt_used,
  input  logic [REG_W-1:0]  rt_idx,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  wr_idx,
  input  logic              is_branch,
  input  logic              is_halt,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_idx,
  input  logic              br_resolve,
  output logic [INST_W-1:0] out_inst,
  output logic              out_valid,
  output logic              stall,
  output logic              halted,
  output logic              err_underflow
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHADOW = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [CNT_W-1:0]  pend [NUM_REGS];

  logic [CNT_W-1:0]  rsPend;
  logic [CNT_W-1:0]  rtPend;
  logic              rsHazard;
  logic              rtHazard;
  logic              rawHazard;
  logic              wawHazard;
  logic              issue;
  logic              underflowHit;
  logic [NUM_REGS-1:0] incVec;
  logic [NUM_REGS-1:0] decVec;

  logic [INST_W-1:0] outInstQ;
  logic              outValidQ;
  logic              errUnderflowQ;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    rsPend   = pend[rs_idx];
    rtPend   = pend[rt_idx];
    rsHazard = rs_used && (rsPend != '0);
    rtHazard = rt_used && (rtPend != '0);
`ifdef WB_BYPASS_EN
    // The last outstanding write lands in the register file this cycle, ahead
    // of the read, so the operand is already good.
    if (rsHazard && (rsPend == CNT_ONE) && wb_valid && (wb_idx == rs_idx)) begin
      rsHazard = 1'b0;
    end
    if (rtHazard && (rtPend == CNT_ONE) && wb_valid && (wb_idx == rt_idx)) begin
      rtHazard = 1'b0;
    end
`endif
  end

  assign rawHazard = rsHazard || rtHazard;
  // The write is held while its counter is full; a writeback in the same cycle
  // does not help because the decision uses the current count.
  assign wawHazard = wr_en && (pend[wr_idx] == CNT_MAX);

  assign stall = in_valid && (rawHazard || wawHazard || (state != IDLE));
  assign issue = in_valid && !stall;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    incVec = '0;
    decVec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      incVec[r] = issue && wr_en && (wr_idx == REG_W'(r));
      decVec[r] = wb_valid && (wb_idx == REG_W'(r)) && (pend[r] != '0);
    end
  end

  assign underflowHit = wb_valid && (pend[wb_idx] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        // Issue and retire on the same register cancel out.
        case ({incVec[r], decVec[r]})
          2'b10:   pend[r] <= pend[r] + CNT_ONE;
          2'b01:   pend[r] <= pend[r] - CNT_ONE;
          default: pend[r] <= pend[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errUnderflowQ <= 1'b0;
    end else if (underflowHit) begin
      errUnderflowQ <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (issue && is_halt) begin
          stateNext = HALT;
        end else if (issue && is_branch) begin
          stateNext = SHADOW;
        end
      end
      SHADOW: begin
        if (br_resolve) begin
          stateNext = IDLE;
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      outInstQ  <= NOP_INST;
      outValidQ <= 1'b0;
    end else if (issue) begin
      outInstQ  <= in_inst;
      outValidQ <= 1'b1;
    end else begin
      outInstQ  <= NOP_INST;
      outValidQ <= 1'b0;
    end
  end

  assign out_inst      = outInstQ;
  assign out_valid     = outValidQ;
  assign halted        = (state == HALT);
  assign err_underflow = errUnderflowQ;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int          INST_W       = 16;
  localparam int          NUM_REGS     = 8;
  localparam int          REG_W        = 3;
  localparam int          MAX_INFLIGHT = 3;
  localparam logic [15:0] NOP          = 16'h0800;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic              rs_used;
  logic [REG_W-1:0]  rs_idx;
  logic              rt_used;
  logic [REG_W-1:0]  rt_idx;
  logic              wr_en;
  logic [REG_W-1:0]  wr_idx;
  logic              is_branch;
  logic              is_halt;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_idx;
  logic              br_resolve;
  logic [INST_W-1:0] out_inst;
  logic              out_valid;
  logic              stall;
  logic              halted;
  logic              err_underflow;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_inst       (in_inst),
    .rs_used       (rs_used),
    .rs_idx        (rs_idx),
    .rt_used       (rt_used),
    .rt_idx        (rt_idx),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .is_branch     (is_branch),
    .is_halt       (is_halt),
    .wb_valid      (wb_valid),
    .wb_idx        (wb_idx),
    .br_resolve    (br_resolve),
    .out_inst      (out_inst),
    .out_valid     (out_valid),
    .stall         (stall),
    .halted        (halted),
    .err_underflow (err_underflow)
  );

  int testCnt = 0;
  int failCnt = 0;

  // Reference model: outstanding write count per register, and a mode
  // (0 normal, 1 waiting for branch, 2 halted).
  int          pendM [NUM_REGS];
  int          modeM;
  bit          errM;
  logic [15:0] expInst;
  bit          expValid;
  bit          lastStall;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    testCnt++;
    assert (obs === want) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic bit srcHaz(bit used, int idx);
    if (!used || pendM[idx] == 0) return 1'b0;
    if (BYPASS && pendM[idx] == 1 && wb_valid && int'(wb_idx) == idx) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NUM_REGS; r++) pendM[r] = 0;
    modeM    = 0;
    errM     = 1'b0;
    expInst  = NOP;
    expValid = 1'b0;
  endtask

  task automatic clearIn();
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_inst    = 16'h0000;
    rs_used    = 1'b0;
    rs_idx     = '0;
    rt_used    = 1'b0;
    rt_idx     = '0;
    wr_en      = 1'b0;
    wr_idx     = '0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    wb_valid   = 1'b0;
    wb_idx     = '0;
    br_resolve = 1'b0;
  endtask

  // One clock: check stall against the model, advance model, check outputs.
  task automatic step(string tag);
    bit expStall;
    bit iss;
    expStall = in_valid && (srcHaz(rs_used, int'(rs_idx)) || srcHaz(rt_used, int'(rt_idx)) ||
               (wr_en && pendM[int'(wr_idx)] == MAX_INFLIGHT) || modeM != 0);
    iss = in_valid && !expStall;
    #2;
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, expStall});
    lastStall = stall;
    if (rst) begin
      modelReset();
    end else begin
      expInst  = iss ? in_inst : NOP;
      expValid = iss;
      if (wb_valid) begin
        if (pendM[int'(wb_idx)] == 0) errM = 1'b1;
        else pendM[int'(wb_idx)]--;
      end
      if (iss && wr_en) pendM[int'(wr_idx)]++;
      case (modeM)
        0: if (iss && is_halt) modeM = 2; else if (iss && is_branch) modeM = 1;
        1: if (br_resolve) modeM = 0;
        default: modeM = 2;
      endcase
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_inst"},  {16'd0, out_inst},       {16'd0, expInst});
    chk({tag, ".out_valid"}, {31'd0, out_valid},      {31'd0, expValid});
    chk({tag, ".halted"},    {31'd0, halted},         {31'd0, (modeM == 2)});
    chk({tag, ".err_uf"},    {31'd0, err_underflow},  {31'd0, errM});
  endtask

  int haltAge;

  initial begin
    modelReset();
    clearIn();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset");
    rst = 1'b0;
    chk("reset.nop_const", {16'd0, out_inst}, {16'd0, NOP});

    // Idle with no fetch: no stall
    step("idle");

    // ADD writes r3
    in_valid = 1'b1; in_inst = 16'h1234; wr_en = 1'b1; wr_idx = 3'd3;
    step("add_r3");
    chk("add_r3.inst_const", {16'd0, out_inst}, 32'h1234);

    // Reader of r3 waits for writeback
    clearIn();
    in_valid = 1'b1; in_inst = 16'h2345; rs_used = 1'b1; rs_idx = 3'd3;
    step("raw_r3");
    chk("raw_r3.stall_const", {31'd0, lastStall}, 32'd1);
    wb_valid = 1'b1; wb_idx = 3'd3;
    step("raw_r3_wb");
    wb_valid = 1'b0;
    if (lastStall) step("raw_r3_after");
    clearIn();
    step("gap0");

    // WAW overflow on r5
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 16'h5000 + 16'(i); wr_en = 1'b1; wr_idx = 3'd5;
      step("waw_fill");
    end
    in_inst = 16'h5003;
    step("waw_4th_stall");
    chk("waw_4th.stall_const", {31'd0, lastStall}, 32'd1);
    wb_valid = 1'b1; wb_idx = 3'd5;
    step("waw_4th_wb");
    wb_valid = 1'b0;
    step("waw_4th_issue");
    in_inst = 16'h5004;
    step("waw_5th_stall");
    clearIn();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_idx = 3'd5;
      step("waw_drain");
    end
    clearIn();

    // Branch shadow: 4 held fetches, resolve on the 5th, issue on the 6th
    in_valid = 1'b1; in_inst = 16'h7000; is_branch = 1'b1;
    step("br_issue");
    is_branch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_inst = 16'h7100;
      step("br_shadow");
    end
    br_resolve = 1'b1;
    step("br_resolve");
    br_resolve = 1'b0;
    step("br_next_issue");
    chk("br_next.valid_const", {31'd0, out_valid}, 32'd1);
    clearIn();

    // br_resolve outside SHADOW is ignored
    br_resolve = 1'b1; in_valid = 1'b1; in_inst = 16'h7200;
    step("br_stray");
    clearIn();

    // Halt
    in_valid = 1'b1; in_inst = 16'hF000; is_halt = 1'b1;
    step("halt_issue");
    is_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_inst = 16'(($urandom & 16'hFFFF));
      step("halt_hold");
    end
    clearIn();
    rst = 1'b1;
    step("halt_rst");
    rst = 1'b0;
    chk("halt_rst.nop_const", {16'd0, out_inst}, {16'd0, NOP});

    // Underflow and same-cycle issue/retire
    wb_valid = 1'b1; wb_idx = 3'd2;
    step("uf_r2");
    clearIn();
    in_valid = 1'b1; in_inst = 16'h6600; rs_used = 1'b1; rs_idx = 3'd2;
    step("uf_r2_read");
    clearIn();
    in_valid = 1'b1; in_inst = 16'h6601; wr_en = 1'b1; wr_idx = 3'd6;
    step("r6_w1");
    in_inst = 16'h6602; wb_valid = 1'b1; wb_idx = 3'd6;
    step("r6_w_wb");
    clearIn();
    in_valid = 1'b1; in_inst = 16'h6603; rt_used = 1'b1; rt_idx = 3'd6;
    step("r6_read_stall");
    clearIn();
    wb_valid = 1'b1; wb_idx = 3'd6;
    step("r6_drain");
    clearIn();

    // Randomized traffic
    haltAge = 0;
    for (int c = 0; c < 600; c++) begin
      clearIn();
      in_valid  = ($urandom_range(0, 99) < 70);
      in_inst   = 16'($urandom);
      rs_used   = ($urandom_range(0, 99) < 50);
      rs_idx    = 3'($urandom_range(0, 7));
      rt_used   = ($urandom_range(0, 99) < 40);
      rt_idx    = 3'($urandom_range(0, 7));
      wr_en     = ($urandom_range(0, 99) < 60);
      wr_idx    = 3'($urandom_range(0, 3));
      is_branch = ($urandom_range(0, 99) < 8);
      is_halt   = ($urandom_range(0, 99) < 2);
      br_resolve = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 45) begin
        int start;
        start = $urandom_range(0, NUM_REGS - 1);
        wb_valid = 1'b1;
        wb_idx   = 3'(start);
        for (int k = 0; k < NUM_REGS; k++) begin
          if (pendM[(start + k) % NUM_REGS] > 0) begin
            wb_idx = 3'((start + k) % NUM_REGS);
            break;
          end
        end
      end
      haltAge = (modeM == 2) ? haltAge + 1 : 0;
      if ($urandom_range(0, 99) < 1 || haltAge > 8) rst = 1'b1;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
